// File: rtl/solver_scheduler.sv
// solver_scheduler: round-robin sequencer for the shared Solver (optional counters: SOLVER_SCHED_CNT_EN)
module solver_scheduler #(
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        enc_req_valid,
  input  logic [59:0] enc_req_data,
  output logic        enc_req_ready,
  input  logic        dec_req_valid,
  input  logic [77:0] dec_req_data,
  output logic        dec_req_ready,
  input  logic        gen_req_valid,
  output logic        gen_req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_src,
  output logic [77:0] rsp_data,
  output logic [59:0] sol_data_1_80,
  output logic [77:0] sol_data_2_96,
  output logic [1:0]  sol_work_2,
  input  logic [77:0] sol_output_1_96,
  input  logic [59:0] sol_output_2_80,
  output logic        busy
`ifdef SOLVER_SCHED_CNT_EN
  ,
  output logic [15:0] cnt_enc,
  output logic [15:0] cnt_dec,
  output logic [15:0] cnt_gen
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [1:0] rr_ptr, grant, c0, c1, c2;
  logic [3:0] valids;
  logic [3:0] cnt;
  logic granted, accept;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  assign valids = {1'b0, gen_req_valid, dec_req_valid, enc_req_valid};
  // round-robin search starting at rr_ptr; work code equals source code so rsp_src doubles as the op
  always_comb begin
    c0 = rr_ptr;
    c1 = nxt(c0);
    c2 = nxt(c1);
    granted = |valids;
    grant = valids[c0] ? c0 : valids[c1] ? c1 : c2;
    accept = state == IDLE && granted;
    enc_req_ready = accept && grant == 2'd0;
    dec_req_ready = accept && grant == 2'd1;
    gen_req_ready = accept && grant == 2'd2;
    rsp_valid = state == RESP;
    busy = state != IDLE;
    sol_work_2 = state == WAIT ? rsp_src : 2'b11;
    state_nxt = state == IDLE ? (granted ? WAIT : IDLE)
              : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
              : (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= state_nxt;
  // operand load on accept, latency countdown and result capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr <= 2'd0;
      rsp_src <= 2'd0;
      rsp_data <= '0;
      sol_data_1_80 <= '0;
      sol_data_2_96 <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        if (grant == 2'd0) sol_data_1_80 <= enc_req_data;
        if (grant == 2'd1) sol_data_2_96 <= dec_req_data;
        rsp_src <= grant;
        cnt <= LATENCY[3:0];
        rr_ptr <= nxt(grant);
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) rsp_data <= rsp_src == 2'd0 ? sol_output_1_96 : {18'b0, sol_output_2_80};
      end
    end
  end
`ifdef SOLVER_SCHED_CNT_EN
  logic hs;
  assign hs = rsp_valid && rsp_ready;
  // per-source saturating response counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_enc <= '0;
      cnt_dec <= '0;
      cnt_gen <= '0;
    end else if (hs) begin
      if (rsp_src == 2'd0 && cnt_enc != 16'hFFFF) cnt_enc <= cnt_enc + 16'd1;
      if (rsp_src == 2'd1 && cnt_dec != 16'hFFFF) cnt_dec <= cnt_dec + 16'd1;
      if (rsp_src == 2'd2 && cnt_gen != 16'hFFFF) cnt_gen <= cnt_gen + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_solver_scheduler.sv
// tb_solver_scheduler: directed checks of solver_scheduler against a stand-in XOR Solver
module tb_solver_scheduler;
  localparam logic [59:0] KEY = 60'h0F0F0F0F0F0F0F0;
  localparam logic [59:0] GEN_VAL = 60'hFEEDC0FFEE12345;
  localparam logic [59:0] PT1 = 60'h0123456789ABCDE;
  localparam logic [77:0] CT1 = {18'h15A5A, 60'h0E2C4A6886A4C2E};
  localparam logic [77:0] CT2 = {18'h15A5A, 60'hF0F0F0F0F0F0F0F};
  logic Clk = 0, Rst_n = 0;
  logic enc_req_valid = 0, dec_req_valid = 0, gen_req_valid = 0, rsp_ready = 0;
  logic [59:0] enc_req_data = '0;
  logic [77:0] dec_req_data = '0;
  logic enc_req_ready, dec_req_ready, gen_req_ready, rsp_valid, busy;
  logic [1:0] rsp_src, sol_work_2;
  logic [77:0] rsp_data, sol_data_2_96, sol_output_1_96;
  logic [59:0] sol_data_1_80, sol_output_2_80;
`ifdef SOLVER_SCHED_CNT_EN
  logic [15:0] cnt_enc, cnt_dec, cnt_gen;
`endif
  int n_vec = 0, n_err = 0;
  always #5 Clk = ~Clk;
  assign sol_output_1_96 = {18'h15A5A, sol_data_1_80 ^ KEY};
  assign sol_output_2_80 = sol_work_2 == 2'd2 ? GEN_VAL : sol_data_2_96[59:0] ^ KEY;
  solver_scheduler #(.LATENCY(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .enc_req_valid(enc_req_valid), .enc_req_data(enc_req_data), .enc_req_ready(enc_req_ready),
    .dec_req_valid(dec_req_valid), .dec_req_data(dec_req_data), .dec_req_ready(dec_req_ready),
    .gen_req_valid(gen_req_valid), .gen_req_ready(gen_req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_data(rsp_data),
    .sol_data_1_80(sol_data_1_80), .sol_data_2_96(sol_data_2_96), .sol_work_2(sol_work_2),
    .sol_output_1_96(sol_output_1_96), .sol_output_2_80(sol_output_2_80), .busy(busy)
`ifdef SOLVER_SCHED_CNT_EN
    , .cnt_enc(cnt_enc), .cnt_dec(cnt_dec), .cnt_gen(cnt_gen)
`endif
  );
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, 80'(rsp_valid), 80'd1);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 80'(busy), 80'd0);
    chk({tag, "_rsp_valid"}, 80'(rsp_valid), 80'd0);
    chk({tag, "_work"}, 80'(sol_work_2), 80'd3);
    chk({tag, "_rsp_data"}, 80'(rsp_data), 80'd0);
    chk({tag, "_rsp_src"}, 80'(rsp_src), 80'd0);
    chk({tag, "_data1"}, 80'(sol_data_1_80), 80'd0);
    chk({tag, "_data2"}, 80'(sol_data_2_96), 80'd0);
    chk({tag, "_readys"}, 80'({enc_req_ready, dec_req_ready, gen_req_ready}), 80'd0);
  endtask
  initial begin
    logic [1:0] grants [4];
    int idle, nv, ng, cnt_rv;
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Rst_n = 1;
    // single encrypt with latency probe
    @(negedge Clk);
    enc_req_valid = 1;
    enc_req_data = PT1;
    #1 chk("enc_ready", 80'(enc_req_ready), 80'd1);
    chk("enc_other_ready", 80'({dec_req_ready, gen_req_ready}), 80'd0);
    @(negedge Clk);
    enc_req_valid = 0;
    chk("enc_busy", 80'(busy), 80'd1);
    chk("enc_work", 80'(sol_work_2), 80'd0);
    chk("enc_data1", 80'(sol_data_1_80), 80'(PT1));
    chk("enc_rv_e1", 80'(rsp_valid), 80'd0);
    @(negedge Clk);
    chk("enc_rv_e2", 80'(rsp_valid), 80'd0);
    chk("enc_work2", 80'(sol_work_2), 80'd0);
    @(negedge Clk);
    chk("enc_rv", 80'(rsp_valid), 80'd1);
    chk("enc_src", 80'(rsp_src), 80'd0);
    chk("enc_rsp_data", 80'(rsp_data), 80'(CT1));
    chk("enc_resp_work", 80'(sol_work_2), 80'd3);
    rsp_ready = 1;
    @(negedge Clk);
    rsp_ready = 0;
    chk("enc_done_rv", 80'(rsp_valid), 80'd0);
    chk("enc_done_busy", 80'(busy), 80'd0);
    // decrypt round trip
    dec_req_valid = 1;
    dec_req_data = CT1;
    #1 chk("dec_ready", 80'(dec_req_ready), 80'd1);
    @(negedge Clk);
    dec_req_valid = 0;
    chk("dec_work", 80'(sol_work_2), 80'd1);
    wait_rsp("dec_wait");
    chk("dec_src", 80'(rsp_src), 80'd1);
    chk("dec_rsp_data", 80'(rsp_data), 80'({18'b0, PT1}));
    rsp_ready = 1;
    @(negedge Clk);
    rsp_ready = 0;
    // regenerate
    gen_req_valid = 1;
    #1 chk("gen_ready", 80'(gen_req_ready), 80'd1);
    @(negedge Clk);
    gen_req_valid = 0;
    chk("gen_work", 80'(sol_work_2), 80'd2);
    chk("gen_data1_kept", 80'(sol_data_1_80), 80'(PT1));
    wait_rsp("gen_wait");
    chk("gen_src", 80'(rsp_src), 80'd2);
    chk("gen_rsp_data", 80'(rsp_data), 80'({18'b0, GEN_VAL}));
    rsp_ready = 1;
    @(negedge Clk);
    // all three held high: expect enc, dec, gen, enc with one idle cycle each
    @(negedge Clk);
    enc_req_valid = 1;
    dec_req_valid = 1;
    gen_req_valid = 1;
    enc_req_data = PT1;
    dec_req_data = CT1;
    idle = 0; nv = 0; ng = 0;
    for (int i = 0; i < 4; i++) grants[i] = 2'd3;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge Clk);
      #1;
      if (!busy) begin
        if (ng < 4) grants[ng] = enc_req_ready ? 2'd0 : dec_req_ready ? 2'd1 : gen_req_ready ? 2'd2 : 2'd3;
        ng++;
        idle++;
      end
      if (rsp_valid) nv++;
    end
    @(negedge Clk);
    enc_req_valid = 0;
    dec_req_valid = 0;
    gen_req_valid = 0;
    chk("rr_g0", 80'(grants[0]), 80'd0);
    chk("rr_g1", 80'(grants[1]), 80'd1);
    chk("rr_g2", 80'(grants[2]), 80'd2);
    chk("rr_g3", 80'(grants[3]), 80'd0);
    chk("rr_idle_cycles", 80'(idle), 80'd4);
    chk("rr_rsp_cycles", 80'(nv), 80'd4);
    rsp_ready = 0;
    @(negedge Clk);
    // backpressure: response held for five cycles with all requests pending
    enc_req_valid = 1;
    enc_req_data = 60'hFFFFFFFFFFFFFFF;
    @(negedge Clk);
    enc_req_valid = 0;
    wait_rsp("bp_wait");
    enc_req_valid = 1;
    dec_req_valid = 1;
    gen_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rv", 80'(rsp_valid), 80'd1);
      chk("bp_data", 80'(rsp_data), 80'(CT2));
      chk("bp_src", 80'(rsp_src), 80'd0);
      chk("bp_work", 80'(sol_work_2), 80'd3);
      chk("bp_readys", 80'({enc_req_ready, dec_req_ready, gen_req_ready}), 80'd0);
      @(negedge Clk);
    end
    enc_req_valid = 0;
    dec_req_valid = 0;
    gen_req_valid = 0;
    rsp_ready = 1;
    @(negedge Clk);
    chk("bp_release_rv", 80'(rsp_valid), 80'd0);
    chk("bp_release_busy", 80'(busy), 80'd0);
    // reset one cycle after accept
    enc_req_valid = 1;
    enc_req_data = PT1;
    @(negedge Clk);
    enc_req_valid = 0;
    Rst_n = 0;
    #1 check_reset_outputs("rst_mid");
    @(negedge Clk);
    Rst_n = 1;
    cnt_rv = 0;
    repeat (8) begin
      @(negedge Clk);
      if (rsp_valid) cnt_rv++;
    end
    chk("rst_no_rsp", 80'(cnt_rv), 80'd0);
`ifdef SOLVER_SCHED_CNT_EN
    chk("cnt_enc_rst", 80'(cnt_enc), 80'd0);
    chk("cnt_dec_rst", 80'(cnt_dec), 80'd0);
    for (int i = 0; i < 3; i++) begin
      enc_req_valid = 1;
      @(negedge Clk);
      enc_req_valid = 0;
      wait_rsp("cnt_wait");
      @(negedge Clk);
    end
    chk("cnt_enc_3", 80'(cnt_enc), 80'd3);
    chk("cnt_dec_0", 80'(cnt_dec), 80'd0);
    chk("cnt_gen_0", 80'(cnt_gen), 80'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
